cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit datapath: program counter, instruction register, decoder, register file, ALU and data memory.
- Sequences fetch / decode / execute / memory / writeback from the decoder's 5-bit opfn.
- Drives PC increment/branch, IR load, register-file write, ALU select and data-memory handshake.
- Provides halt/resume, a memory-timeout error and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 15, max cycles waiting on mem_ready before bus error (1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  leave IDLE and start fetching
- resume  in  1  leave HALT and continue at the next instruction
- opfn  in  5  decoded opcode from the decoder, valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  data memory completes the access this cycle
- ir_load  out  1  capture instruction into the IR
- pc_inc  out  1  PC <= PC+1 next edge
- pc_branch  out  1  PC <= PC+imm next edge (never with pc_inc)
- rf_we  out  1  register-file write of rd
- wb_sel_mem  out  1  writeback source: 1 = memory data, 0 = ALU
- alu_src_imm  out  1  ALU operand B = imm
- alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 xor
- mem_rd  out  1  data-memory read request
- mem_wr  out  1  data-memory write request
- halted  out  1  in HALT state
- bus_err  out  1  sticky memory-timeout flag
- illegal  out  1  one-cycle pulse on an undefined opfn
- retired  out  CNT_W  instructions retired, wraps
- state  out  3  current state: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, BRANCH 6, HALT 7

Behaviour:
- Reset:
  - rst=1 at an edge: state=IDLE, bus_err=0, retired=0, wait counter=0.
  - All other outputs are combinational from state/opfn; in IDLE they are all 0.
  - rst mid-access drops mem_rd/mem_wr on the next cycle.
- Opcodes:
  - 00000 NOP; 00001 ADD; 00010 SUB; 00011 AND; 00100 OR; 00101 XOR.
  - 00110 ADDI; 01000 LD; 01001 ST; 01010 BEQ; 01011 JMP; 11111 HALT.
  - All others are illegal.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: ir_load=1; -> DECODE. Exactly one cycle.
- DECODE:
  - ALU ops/ADDI -> EXEC.
  - LD/ST -> MEM.
  - BEQ/JMP -> BRANCH.
  - HALT -> HALT with pc held.
  - NOP -> FETCH with pc_inc=1 (retires).
  - Illegal -> FETCH with pc_inc=1 and illegal=1 (retires as NOP).
- EXEC: alu_op set from opfn (ADDI uses add, alu_src_imm=1); -> WB.
- WB:
  - rf_we=1, pc_inc=1, alu_op/alu_src_imm held as in EXEC; -> FETCH.
  - wb_sel_mem=1 only for LD.
- MEM:
  - LD: mem_rd=1, alu_op=add, alu_src_imm=1 (address = ra+imm).
  - ST: mem_wr=1, same address generation.
  - Requests held high until a cycle with mem_ready=1.
  - On ready: LD -> WB; ST -> FETCH with pc_inc=1.
  - Wait counter increments on each not-ready cycle. When it reaches MEM_TIMEOUT with mem_ready still 0: bus_err<=1, -> HALT, no pc update.
  - Counter clears on MEM exit.
- BRANCH:
  - alu_op=sub for compare.
  - JMP, or BEQ with zero=1: pc_branch=1. BEQ with zero=0: pc_inc=1.
  - -> FETCH.
- HALT:
  - halted=1.
  - resume=1 and bus_err=0: pc_inc=1, -> FETCH.
  - resume is ignored while bus_err=1; only rst clears it.
- retired: increments by 1 in every cycle where pc_inc|pc_branch is high; wraps from 2^CNT_W-1 to 0.
- Latency:
  - ALU op = 4 cycles (F, D, E, W).
  - LD = 4 + wait cycles.
  - ST and branch = 3 cycles (ST + wait cycles).
  - NOP = 2 cycles.
- run and resume are level-sensitive and are ignored outside IDLE/HALT.

Test Plan:
- rst high 2 cycles, then run=1 with program ADD, ADDI -> states 1,2,3,5,1,2,3,5; rf_we high exactly at the two WB cycles; alu_src_imm=1 only for ADDI; retired=2.
- LD with mem_ready low 3 cycles, then high -> mem_rd high 4 cycles; then WB with wb_sel_mem=1; retired increments once.
- BEQ with zero=0, then BEQ with zero=1, then JMP -> pc_inc, pc_branch, pc_branch in the respective BRANCH cycles; pc_inc and pc_branch never both high.
- ST with mem_ready held 0 -> bus_err=1 and state=7 after MEM_TIMEOUT not-ready cycles; resume=1 keeps state=7; rst clears bus_err and returns to IDLE.
- HALT opcode -> halted=1, retired unchanged; resume pulse -> pc_inc one cycle, then FETCH. Illegal opfn 10101 -> illegal pulse and retires as NOP.
- CNT_W=4, 17 NOPs -> retired=1 after wrap; rst asserted during MEM -> mem_rd low the following cycle, state=0.

Source files
------------

// File: rtl/cpu_ctrl_fsm_if.sv
// Data-memory handshake between the multi-cycle control unit and data memory.
// The controller raises mem_rd/mem_wr and holds them until memory returns mem_ready.
interface cpu_ctrl_fsm_if;
    logic mem_rd;
    logic mem_wr;
    logic mem_ready;

    modport master (
        output mem_rd,
        output mem_wr,
        input  mem_ready
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        output mem_ready
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: fetch/decode/execute/memory/writeback
// sequencing, halt/resume, memory-timeout bus error and a retired-instruction counter.
module cpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             resume,
    input  logic [4:0]       opfn,
    input  logic             zero,
    cpu_ctrl_fsm_if.master   mem,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic             rf_we,
    output logic             wb_sel_mem,
    output logic             alu_src_imm,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    // state  | meaning
    // IDLE   | waiting for run
    // FETCH  | load IR from instruction memory
    // DECODE | dispatch on opfn; NOP/illegal retire here
    // EXEC   | ALU operation
    // MEM    | data-memory access, waiting on mem_ready
    // WB     | register-file write, PC increment
    // BRANCH | BEQ/JMP PC update
    // HALT   | stopped until resume (blocked by bus_err)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_XOR  = 5'b00101;
    localparam logic [4:0] OP_ADDI = 5'b00110;
    localparam logic [4:0] OP_LD   = 5'b01000;
    localparam logic [4:0] OP_ST   = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_JMP  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             bus_err_q;
    logic             set_bus_err;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;

    logic             is_alu;
    logic             is_addi;
    logic             is_ld;
    logic             is_st;
    logic             is_branch;
    logic             is_jmp;
    logic             is_halt;
    logic             is_nop;
    logic [2:0]       alu_fn;

    logic             mem_rd_c;
    logic             mem_wr_c;

    always_comb begin
        is_alu    = 1'b0;
        is_addi   = 1'b0;
        is_ld     = 1'b0;
        is_st     = 1'b0;
        is_branch = 1'b0;
        is_jmp    = 1'b0;
        is_halt   = 1'b0;
        is_nop    = 1'b0;
        alu_fn    = ALU_ADD;
        case (opfn)
            OP_NOP:  is_nop = 1'b1;
            OP_ADD:  begin is_alu = 1'b1; alu_fn = ALU_ADD; end
            OP_SUB:  begin is_alu = 1'b1; alu_fn = ALU_SUB; end
            OP_AND:  begin is_alu = 1'b1; alu_fn = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1; alu_fn = ALU_OR;  end
            OP_XOR:  begin is_alu = 1'b1; alu_fn = ALU_XOR; end
            OP_ADDI: begin is_addi = 1'b1; alu_fn = ALU_ADD; end
            OP_LD:   is_ld = 1'b1;
            OP_ST:   is_st = 1'b1;
            OP_BEQ:  is_branch = 1'b1;
            OP_JMP:  begin is_branch = 1'b1; is_jmp = 1'b1; end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bus_err_q <= 1'b0;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
            // Staying in MEM means this was a not-ready cycle; any exit clears it.
            if (state_q == S_MEM && state_d == S_MEM) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (pc_inc || pc_branch) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        set_bus_err = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        rf_we       = 1'b0;
        wb_sel_mem  = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        mem_rd_c    = 1'b0;
        mem_wr_c    = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu || is_addi) begin
                    state_d = S_EXEC;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    state_d = S_BRANCH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    pc_inc  = 1'b1;
                    illegal = !is_nop;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op      = alu_fn;
                alu_src_imm = is_addi;
                state_d     = S_WB;
            end
            S_WB: begin
                rf_we       = 1'b1;
                pc_inc      = 1'b1;
                wb_sel_mem  = is_ld;
                alu_op      = alu_fn;
                alu_src_imm = is_addi || is_ld;
                state_d     = S_FETCH;
            end
            S_MEM: begin
                alu_op      = ALU_ADD;
                alu_src_imm = 1'b1;
                mem_rd_c    = is_ld;
                mem_wr_c    = !is_ld;
                if (mem.mem_ready) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                // wait_cnt counts earlier not-ready cycles, so this is the MEM_TIMEOUT-th one.
                end else if (wait_cnt == WAIT_LAST) begin
                    set_bus_err = 1'b1;
                    state_d     = S_HALT;
                end
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                if (is_jmp || zero) begin
                    pc_branch = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume && !bus_err_q) begin
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem.mem_rd = mem_rd_c;
    assign mem.mem_wr = mem_wr_c;
    assign bus_err    = bus_err_q;
    assign retired    = retired_q;
    assign state      = 3'(state_q);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: an instruction-level model expands each instruction into its
// expected per-cycle phases; a CNT_W=4 twin runs in lockstep to exercise counter wrap.
module tb_cpu_ctrl_fsm;
    localparam int T = 5;

    localparam logic [12:0] C_IR  = 13'h1000;
    localparam logic [12:0] C_INC = 13'h0800;
    localparam logic [12:0] C_BR  = 13'h0400;
    localparam logic [12:0] C_WE  = 13'h0200;
    localparam logic [12:0] C_WBM = 13'h0100;
    localparam logic [12:0] C_IMM = 13'h0080;
    localparam logic [12:0] C_RD  = 13'h0008;
    localparam logic [12:0] C_WR  = 13'h0004;
    localparam logic [12:0] C_HLT = 13'h0002;
    localparam logic [12:0] C_ILL = 13'h0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run, resume, zero, mem_ready;
    logic [4:0] opfn;

    cpu_ctrl_fsm_if bus ();
    cpu_ctrl_fsm_if bus4 ();
    assign bus.mem_ready  = mem_ready;
    assign bus4.mem_ready = mem_ready;

    logic        ir_load, pc_inc, pc_branch, rf_we, wb_sel_mem, alu_src_imm, halted, bus_err, illegal;
    logic [2:0]  alu_op, state;
    logic [15:0] retired;
    logic        ir_load_w, pc_inc_w, pc_branch_w, rf_we_w, wb_sel_mem_w, alu_src_imm_w, halted_w, bus_err_w, illegal_w;
    logic [2:0]  alu_op_w, state_w;
    logic [3:0]  retired_w;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .resume(resume), .opfn(opfn), .zero(zero),
        .mem(bus.master), .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
        .rf_we(rf_we), .wb_sel_mem(wb_sel_mem), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .halted(halted), .bus_err(bus_err), .illegal(illegal), .retired(retired), .state(state)
    );

    cpu_ctrl_fsm #(.MEM_TIMEOUT(T), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .resume(resume), .opfn(opfn), .zero(zero),
        .mem(bus4.master), .ir_load(ir_load_w), .pc_inc(pc_inc_w), .pc_branch(pc_branch_w),
        .rf_we(rf_we_w), .wb_sel_mem(wb_sel_mem_w), .alu_src_imm(alu_src_imm_w), .alu_op(alu_op_w),
        .halted(halted_w), .bus_err(bus_err_w), .illegal(illegal_w), .retired(retired_w), .state(state_w)
    );

    logic [12:0] ctl, ctl_w;
    assign ctl   = {ir_load, pc_inc, pc_branch, rf_we, wb_sel_mem, alu_src_imm, alu_op,
                    bus.mem_rd, bus.mem_wr, halted, illegal};
    assign ctl_w = {ir_load_w, pc_inc_w, pc_branch_w, rf_we_w, wb_sel_mem_w, alu_src_imm_w, alu_op_w,
                    bus4.mem_rd, bus4.mem_wr, halted_w, illegal_w};

    typedef struct packed {
        logic [2:0]  st;
        logic [12:0] ctl;
        logic [4:0]  op;
        logic        zr;
        logic        rdy;
        logic        rsm;
        logic        rn;
        logic        berr;
        logic [31:0] ret;
    } cyc_t;

    cyc_t        sched[$];
    int unsigned n_ret;
    logic        berr_m;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [12:0] aop(input int a);
        return 13'(a) << 4;
    endfunction

    // 0 nop, 1 reg alu, 2 addi, 3 ld, 4 st, 5 beq, 6 jmp, 7 halt, 8 illegal
    function automatic int kind(input logic [4:0] op);
        case (op)
            5'd0:                          return 0;
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5:  return 1;
            5'd6:                          return 2;
            5'd8:                          return 3;
            5'd9:                          return 4;
            5'd10:                         return 5;
            5'd11:                         return 6;
            5'd31:                         return 7;
            default:                       return 8;
        endcase
    endfunction

    task automatic push(input logic [2:0] st, input logic [12:0] c, input logic [4:0] op,
                        input logic zr, input logic rdy, input logic rsm, input logic rn);
        cyc_t e;
        e.st = st; e.ctl = c; e.op = op; e.zr = zr; e.rdy = rdy; e.rsm = rsm; e.rn = rn;
        e.berr = berr_m; e.ret = 32'(n_ret);
        sched.push_back(e);
    endtask

    task automatic push_instr(input logic [4:0] op, input logic zr, input int waits, input int hw);
        int k;
        logic [12:0] m;
        k = kind(op);
        push(3'd1, C_IR, op, zr, rb(), rb(), rb());
        case (k)
            0: begin push(3'd2, C_INC, op, zr, rb(), rb(), rb()); n_ret++; end
            8: begin push(3'd2, C_INC | C_ILL, op, zr, rb(), rb(), rb()); n_ret++; end
            1, 2: begin
                m = aop(k == 2 ? 0 : int'(op) - 1) | (k == 2 ? C_IMM : 13'h0);
                push(3'd2, 13'h0, op, zr, rb(), rb(), rb());
                push(3'd3, m, op, zr, rb(), rb(), rb());
                push(3'd5, m | C_WE | C_INC, op, zr, rb(), rb(), rb());
                n_ret++;
            end
            3, 4: begin
                m = (k == 3 ? C_RD : C_WR) | C_IMM;
                push(3'd2, 13'h0, op, zr, rb(), rb(), rb());
                if (waits < T) begin
                    for (int i = 0; i < waits; i++) push(3'd4, m, op, zr, 1'b0, rb(), rb());
                    if (k == 3) begin
                        push(3'd4, m, op, zr, 1'b1, rb(), rb());
                        push(3'd5, C_WE | C_INC | C_WBM | C_IMM, op, zr, rb(), rb(), rb());
                    end else begin
                        push(3'd4, m | C_INC, op, zr, 1'b1, rb(), rb());
                    end
                    n_ret++;
                end else begin
                    for (int i = 0; i < T; i++) push(3'd4, m, op, zr, 1'b0, rb(), rb());
                    berr_m = 1'b1;
                    for (int i = 0; i <= hw; i++) push(3'd7, C_HLT, op, zr, rb(), 1'b1, rb());
                end
            end
            5, 6: begin
                push(3'd2, 13'h0, op, zr, rb(), rb(), rb());
                push(3'd6, aop(1) | ((k == 6 || zr) ? C_BR : C_INC), op, zr, rb(), rb(), rb());
                n_ret++;
            end
            default: begin
                push(3'd2, 13'h0, op, zr, rb(), rb(), rb());
                for (int i = 0; i < hw; i++) push(3'd7, C_HLT, op, zr, rb(), 1'b0, rb());
                push(3'd7, C_HLT | C_INC, op, zr, rb(), 1'b1, rb());
                n_ret++;
            end
        endcase
    endtask

    task automatic play(input int max_cyc);
        cyc_t c;
        int   k;
        k = 0;
        while (sched.size() > 0 && k < max_cyc) begin
            c = sched.pop_front();
            opfn = c.op; zero = c.zr; mem_ready = c.rdy; resume = c.rsm; run = c.rn;
            @(negedge clk);
            chk("state", 32'(state), 32'(c.st));
            chk("ctl", 32'(ctl), 32'(c.ctl));
            chk("retired", 32'(retired), 32'(c.ret[15:0]));
            chk("bus_err", 32'(bus_err), 32'(c.berr));
            chk("state_w4", 32'(state_w), 32'(c.st));
            chk("ctl_w4", 32'(ctl_w), 32'(c.ctl));
            chk("retired_w4", 32'(retired_w), 32'(c.ret[3:0]));
            chk("inc_br_excl", 32'(pc_inc & pc_branch), 32'(0));
            @(posedge clk);
            #1;
            cyc_no++;
            k++;
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1; run = 1'b0; resume = 1'b0; mem_ready = 1'b0; zero = 1'b0; opfn = 5'd0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            cyc_no++;
        end
        @(negedge clk);
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_ctl", 32'(ctl), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        chk("rst_bus_err", 32'(bus_err), 32'(0));
        chk("rst_retired_w4", 32'(retired_w), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ret = 0;
        berr_m = 1'b0;
    endtask

    logic [4:0] legal_ops [12];
    logic [4:0] rop;

    initial begin
        legal_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd31};
        n_ret = 0;
        berr_m = 1'b0;
        do_reset(2);

        push(3'd0, 13'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(3'd0, 13'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_instr(5'd1, 1'b0, 0, 0);       // ADD
        push_instr(5'd6, 1'b0, 0, 0);       // ADDI
        push_instr(5'd8, 1'b0, 3, 0);       // LD, 3 wait cycles
        push_instr(5'd10, 1'b0, 0, 0);      // BEQ not taken
        push_instr(5'd10, 1'b1, 0, 0);      // BEQ taken
        push_instr(5'd11, 1'b0, 0, 0);      // JMP
        push_instr(5'd31, 1'b0, 0, 2);      // HALT, resume after 2 cycles
        push_instr(5'b10101, 1'b0, 0, 0);   // illegal
        for (int i = 0; i < 17; i++) push_instr(5'd0, 1'b0, 0, 0);
        push_instr(5'd9, 1'b0, T - 1, 0);   // ST, last cycle before timeout
        push_instr(5'd8, 1'b0, T - 1, 0);
        push_instr(5'd8, 1'b0, 0, 0);
        push_instr(5'd31, 1'b0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(0, 31));
            else rop = legal_ops[$urandom_range(0, 11)];
            push_instr(rop, rb(), $urandom_range(0, T - 1), $urandom_range(0, 2));
        end
        push_instr(5'd9, 1'b0, T, 3);       // ST timeout, resume ignored
        play(100000);

        do_reset(1);
        push(3'd0, 13'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_instr(5'd8, 1'b0, T - 1, 0);
        play(4);
        sched.delete();
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_mem_rd", 32'(bus.mem_rd), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(state), 32'(0));
        chk("post_rst_mem_rd", 32'(bus.mem_rd), 32'(0));
        chk("post_rst_ctl", 32'(ctl), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
